hw_stack: RTL and testbench
===========================

// Module: hw_stack
// PURPOSE
//   Parametrised hardware stack: SP register with on-chip storage, push/pop data path,
//   full/empty status, sticky overflow/underflow flags and a high-water mark. It serves as
//   the CPU call/data stack and replaces the bare SP counter. SP counts stored entries.
//   The next push writes mem[SP] and the top of stack is mem[SP-1].
// PARAMETERS
//   DATA_W  32  width of stack entries
//   DEPTH   16  number of entries, >=2
//   SP_W    $clog2(DEPTH+1)  SP width (derived localparam, not overridable)
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   push         in   1       push push_data this cycle
//   push_data    in   DATA_W  data to push
//   pop          in   1       pop top entry this cycle
//   sp_load      in   1       load SP from sp_load_val (highest priority)
//   sp_load_val  in   SP_W    new SP value; saturates to DEPTH
//   err_clr      in   1       clear overflow/underflow sticky flags
//   pop_data     out  DATA_W  popped entry, registered
//   pop_valid    out  1       1-cycle strobe: pop_data updated
//   sp           out  SP_W    current entry count
//   empty        out  1       sp==0 (combinational from sp)
//   full         out  1       sp==DEPTH (combinational from sp)
//   overflow     out  1       sticky: a push was dropped
//   underflow    out  1       sticky: a pop hit an empty stack
//   high_water   out  SP_W    maximum sp reached since reset
// BEHAVIOUR
//   Reset: sp=0, pop_data=0, pop_valid=0, overflow=0, underflow=0, high_water=0.
//     Memory contents are not reset.
//   Per-cycle priority:
//     - sp_load=1: sp<=min(sp_load_val,DEPTH); push/pop ignored, no flags set, pop_valid=0.
//     - push only, !full: mem[sp]<=push_data; sp<=sp+1.
//     - push only, full: write dropped; sp unchanged; overflow<=1.
//     - pop only, !empty: pop_data<=mem[sp-1]; pop_valid<=1 next cycle; sp<=sp-1.
//     - pop only, empty: sp unchanged; pop_data holds; pop_valid=0; underflow<=1.
//     - push&pop, !empty: replace top. pop_data<=old mem[sp-1]; mem[sp-1]<=push_data;
//       pop_valid<=1; sp unchanged. Legal when full; no overflow.
//     - push&pop, empty: pop fails (underflow<=1, pop_valid=0); push proceeds (sp<=1).
//   Latency: pop_data/pop_valid valid the cycle after the pop edge. A push is readable
//     by a pop issued on the next cycle (no bypass needed; write completes at the edge).
//   pop_valid is a single-cycle pulse. Back-to-back pops give consecutive pulses.
//   high_water<=max(high_water,next sp) every cycle. This includes sp_load.
//   err_clr clears both sticky flags. A new error in the same cycle wins (flag stays 1).
//   SP never wraps: no increment past DEPTH and no decrement below 0 under any input.
//   rst asserted mid-operation: all outputs return to reset values immediately (async).
//     Any in-flight pop result is lost.
// TESTING  (DEPTH=4, DATA_W=32)
//   Push 0xA,0xB,0xC,0xD -> sp=4, full=1, high_water=4. A 5th push of 0xE -> overflow=1,
//     sp=4. Then pop x4 -> pop_data 0xD,0xC,0xB,0xA, each with one-cycle pop_valid, sp=0.
//   Pop on empty -> underflow=1, pop_valid=0, pop_data unchanged. Then err_clr -> underflow=0.
//     Pop+err_clr in the same cycle while empty -> underflow stays 1.
//   sp=2 (0x1,0x2), push 0x9 & pop together -> pop_data=0x2, sp=2; next pop returns 0x9.
//   sp_load_val=7 with push=1 -> sp=4 (saturated), no write, no flags. sp_load_val=1 -> sp=1,
//     high_water stays 4.
//   Async rst asserted mid-sequence between clock edges (sp=3) -> sp=0, flags=0,
//     pop_valid=0, high_water=0 without waiting for clk.
//   Empty stack, push 0x5 & pop together -> underflow=1, sp=1; next pop returns 0x5.

Source files
------------

// File: rtl/hw_stack.sv
// Parametrised hardware stack: SP counts stored entries, mem[SP] is the next free slot and
// mem[SP-1] is the top. Registered pop path, sticky error flags and a high-water mark.
module hw_stack #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              sp_load,
  input  logic [SP_W-1:0]   sp_load_val,
  input  logic              err_clr,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [SP_W-1:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [SP_W-1:0]   high_water
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [SP_W-1:0]   sp_q,        sp_d;
  logic [DATA_W-1:0] pop_data_q,  pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;
  logic [SP_W-1:0]   hw_q,        hw_d;

  logic              empty_w, full_w;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     top_addr;
  logic              ovf_set, unf_set;

  assign empty_w  = (sp_q == '0);
  assign full_w   = (sp_q == DEPTH_SP);
  assign top_addr = AW'(sp_q - SP_W'(1));

  always_comb begin
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = AW'(sp_q);
    ovf_set     = 1'b0;
    unf_set     = 1'b0;

    if (sp_load) begin
      sp_d = (sp_load_val > DEPTH_SP) ? DEPTH_SP : sp_load_val;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full_w) begin
            ovf_set = 1'b1;
          end else begin
            mem_we = 1'b1;
            sp_d   = sp_q + SP_W'(1);
          end
        end
        2'b01: begin
          if (empty_w) begin
            unf_set = 1'b1;
          end else begin
            pop_data_d  = mem_q[top_addr];
            pop_valid_d = 1'b1;
            sp_d        = sp_q - SP_W'(1);
          end
        end
        2'b11: begin
          // Push+pop on a non-empty stack replaces the top in place, so full is not an issue.
          if (empty_w) begin
            unf_set = 1'b1;
            mem_we  = 1'b1;
            sp_d    = SP_W'(1);
          end else begin
            pop_data_d  = mem_q[top_addr];
            pop_valid_d = 1'b1;
            mem_we      = 1'b1;
            mem_waddr   = top_addr;
          end
        end
        default: begin
        end
      endcase
    end

    overflow_d  = ovf_set | (overflow_q  & ~err_clr);
    underflow_d = unf_set | (underflow_q & ~err_clr);
    hw_d        = (sp_d > hw_q) ? sp_d : hw_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q        <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      hw_q        <= '0;
    end else begin
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      hw_q        <= hw_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= push_data;
    end
  end

  assign pop_data   = pop_data_q;
  assign pop_valid  = pop_valid_q;
  assign sp         = sp_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign high_water = hw_q;

endmodule

// File: tb/tb_hw_stack.sv
// Self-checking bench for hw_stack (DEPTH=4): a pop-then-push reference model checked
// every negedge, plus directed vectors with hand-computed literal expectations.
module tb_hw_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic [DATA_W-1:0] pushData = '0;
  logic              pop = 1'b0;
  logic              spLoad = 1'b0;
  logic [SP_W-1:0]   spLoadVal = '0;
  logic              errClr = 1'b0;
  logic [DATA_W-1:0] popData;
  logic              popValid;
  logic [SP_W-1:0]   sp;
  logic              empty, full, overflow, underflow;
  logic [SP_W-1:0]   highWater;

  int checks   = 0;
  int failures = 0;

  hw_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(pushData), .pop(pop),
    .sp_load(spLoad), .sp_load_val(spLoadVal), .err_clr(errClr),
    .pop_data(popData), .pop_valid(popValid), .sp(sp), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .high_water(highWater)
  );

  always #5 clk = ~clk;

  // Reference model: a failed pop is skipped, a successful pop happens before the push.
  int          mSp;
  int          mHw;
  logic [31:0] mMem [DEPTH];
  logic [31:0] mPopData;
  logic        mPopValid, mOvf, mUnf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mSp = 0; mHw = 0; mPopData = '0; mPopValid = 1'b0; mOvf = 1'b0; mUnf = 1'b0;
    end else begin
      int  nsp;
      bit  popOk, pushOk, ovfNew, unfNew;
      nsp = mSp; mPopValid = 1'b0; ovfNew = 0; unfNew = 0;
      if (spLoad) begin
        nsp = (int'(spLoadVal) > DEPTH) ? DEPTH : int'(spLoadVal);
      end else begin
        popOk  = pop && (mSp > 0);
        pushOk = push && ((mSp < DEPTH) || popOk);
        unfNew = pop && (mSp == 0);
        ovfNew = push && !pushOk;
        if (popOk) begin
          mPopData = mMem[nsp-1]; mPopValid = 1'b1; nsp = nsp - 1;
        end
        if (pushOk) begin
          mMem[nsp] = pushData; nsp = nsp + 1;
        end
      end
      mOvf = ovfNew || (mOvf && !errClr);
      mUnf = unfNew || (mUnf && !errClr);
      mSp  = nsp;
      if (nsp > mHw) mHw = nsp;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model.sp",         32'(sp),        32'(mSp));
    checkOutput("model.empty",      32'(empty),     32'(mSp == 0));
    checkOutput("model.full",       32'(full),      32'(mSp == DEPTH));
    checkOutput("model.overflow",   32'(overflow),  32'(mOvf));
    checkOutput("model.underflow",  32'(underflow), 32'(mUnf));
    checkOutput("model.high_water", 32'(highWater), 32'(mHw));
    checkOutput("model.pop_valid",  32'(popValid),  32'(mPopValid));
    checkOutput("model.pop_data",   popData,        mPopData);
  end

  // One clock of stimulus; returns #1 after the edge so results can be inspected.
  task automatic applyStimulus(input logic pu, input logic [31:0] d, input logic po,
                               input logic ld, input logic [SP_W-1:0] lv, input logic clr);
    @(negedge clk);
    push = pu; pushData = d; pop = po; spLoad = ld; spLoadVal = lv; errClr = clr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; spLoad = 1'b0; errClr = 1'b0;
  endtask

  task automatic doPush(input logic [31:0] d); applyStimulus(1, d, 0, 0, '0, 0); endtask
  task automatic doPop();                      applyStimulus(0, '0, 1, 0, '0, 0); endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.sp",         32'(sp),        0);
    checkOutput("reset.empty",      32'(empty),     1);
    checkOutput("reset.pop_data",   popData,        0);
    checkOutput("reset.high_water", 32'(highWater), 0);

    doPush(32'hA); doPush(32'hB); doPush(32'hC); doPush(32'hD);
    checkOutput("fill.sp",         32'(sp),        4);
    checkOutput("fill.full",       32'(full),      1);
    checkOutput("fill.high_water", 32'(highWater), 4);
    doPush(32'hE);
    checkOutput("ovf.overflow", 32'(overflow), 1);
    checkOutput("ovf.sp",       32'(sp),       4);

    doPop(); checkOutput("pop1.data", popData, 32'hD); checkOutput("pop1.valid", 32'(popValid), 1);
    doPop(); checkOutput("pop2.data", popData, 32'hC); checkOutput("pop2.valid", 32'(popValid), 1);
    doPop(); checkOutput("pop3.data", popData, 32'hB); checkOutput("pop3.valid", 32'(popValid), 1);
    doPop(); checkOutput("pop4.data", popData, 32'hA); checkOutput("pop4.valid", 32'(popValid), 1);
    checkOutput("pop4.sp", 32'(sp), 0);
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("idle.valid", 32'(popValid), 0);

    doPop();
    checkOutput("unf.underflow", 32'(underflow), 1);
    checkOutput("unf.valid",     32'(popValid),  0);
    checkOutput("unf.data",      popData,        32'hA);
    applyStimulus(0, '0, 0, 0, '0, 1);
    checkOutput("clr.underflow", 32'(underflow), 0);
    checkOutput("clr.overflow",  32'(overflow),  0);
    applyStimulus(0, '0, 1, 0, '0, 1);
    checkOutput("clrwin.underflow", 32'(underflow), 1);
    applyStimulus(0, '0, 0, 0, '0, 1);

    doPush(32'h1); doPush(32'h2);
    applyStimulus(1, 32'h9, 1, 0, '0, 0);
    checkOutput("replace.data", popData,    32'h2);
    checkOutput("replace.sp",   32'(sp),    2);
    checkOutput("replace.ovf",  32'(overflow), 0);
    doPop();
    checkOutput("replace.next", popData, 32'h9);

    applyStimulus(1, 32'hFF, 0, 1, SP_W'(7), 0);
    checkOutput("load.sp",    32'(sp),        4);
    checkOutput("load.valid", 32'(popValid),  0);
    checkOutput("load.ovf",   32'(overflow),  0);
    doPop();
    checkOutput("load.nowrite", popData, 32'hD);
    applyStimulus(0, '0, 0, 1, SP_W'(1), 0);
    checkOutput("load1.sp", 32'(sp),        1);
    checkOutput("load1.hw", 32'(highWater), 4);

    applyStimulus(0, '0, 0, 1, SP_W'(0), 0);
    doPop();
    doPush(32'h7); doPush(32'h8); doPush(32'h9); doPush(32'h3);
    doPop();
    checkOutput("pre_rst.sp",    32'(sp),        3);
    checkOutput("pre_rst.valid", 32'(popValid),  1);
    checkOutput("pre_rst.unf",   32'(underflow), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async.sp",        32'(sp),        0);
    checkOutput("async.valid",     32'(popValid),  0);
    checkOutput("async.underflow", 32'(underflow), 0);
    checkOutput("async.hw",        32'(highWater), 0);
    checkOutput("async.data",      popData,        0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1, 32'h5, 1, 0, '0, 0);
    checkOutput("empty_pp.underflow", 32'(underflow), 1);
    checkOutput("empty_pp.sp",        32'(sp),        1);
    checkOutput("empty_pp.valid",     32'(popValid),  0);
    doPop();
    checkOutput("empty_pp.next", popData, 32'h5);
    applyStimulus(0, '0, 0, 0, '0, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
